// File: rtl/register_file_sb.sv
// Integer register file with combinational read ports and a per-register busy
// scoreboard; x0 is hardwired to zero and never marked busy.
module register_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_addr,
    input  logic                   flush,
    output logic [NREGS-1:0]       busy_vec,
    output logic [AW:0]            busy_count
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      count_next;
    logic             wr_act;
    logic             issue_act;

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + (AW+1)'(v[i]);
        end
        return c;
    endfunction

    assign wr_act    = wr_en && (wr_addr != '0);
    assign issue_act = issue_en && (issue_addr != '0);

    // Issue is applied last so a new producer wins over a same-edge clear.
    always_comb begin
        busy_next = busy_vec;
        if (flush) begin
            busy_next = '0;
        end
        if (wr_act) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (issue_act) begin
            busy_next[issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    assign count_next = popcount(busy_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_vec   <= '0;
            busy_count <= '0;
        end else begin
            busy_vec   <= busy_next;
            busy_count <= count_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_act) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Forwarding is suppressed during reset so every port reads zero.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if ((BYPASS != 0) && !reset && wr_act && (rd_addr[i*AW +: AW] == wr_addr)) begin
                rd_data[i*XLEN +: XLEN] = wr_data;
                rd_busy[i]              = issue_act && (issue_addr == wr_addr);
            end else begin
                rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
                rd_busy[i]              = busy_vec[rd_addr[i*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: a bypassing and a non-bypassing instance share
// inputs and are compared every cycle against an array-based model.
module tb_register_file_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREAD*AW-1:0]   rd_addr;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  issue_en;
    logic [AW-1:0]         issue_addr;
    logic                  flush;

    logic [NREAD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NREAD-1:0]      rd_busy_b, rd_busy_n;
    logic [NREGS-1:0]      busy_vec_b, busy_vec_n;
    logic [AW:0]           busy_count_b, busy_count_n;

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;

    register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut (
        .clk(clk), .reset(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .busy_vec(busy_vec_b), .busy_count(busy_count_b)
    );

    register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .busy_vec(busy_vec_n), .busy_count(busy_count_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference state: plain arrays updated by the architectural rules.
    logic [XLEN-1:0]  mregs [NREGS];
    logic [NREGS-1:0] mbusy;

    function automatic logic [NREGS-1:0] model_busy(input logic [NREGS-1:0] b,
            input logic we, input logic [AW-1:0] wa, input logic ie,
            input logic [AW-1:0] ia, input logic fl);
        logic [NREGS-1:0] r;
        r = fl ? '0 : b;
        if (we && wa != 0) r[wa] = 1'b0;
        if (ie && ia != 0) r[ia] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mregs[i] <= '0;
            mbusy <= '0;
        end else begin
            if (wr_en && wr_addr != 0) mregs[wr_addr] <= wr_data;
            mbusy <= model_busy(mbusy, wr_en, wr_addr, issue_en, issue_addr, flush);
        end
    end

    always @(negedge clk) begin : compare
        logic [AW-1:0]   a;
        logic [XLEN-1:0] sd, ed;
        logic            sb, eb, fwd;
        if (cmp_on) begin
            for (int i = 0; i < NREAD; i++) begin
                a   = rd_addr[i*AW +: AW];
                sd  = (rst || a == 0) ? '0 : mregs[a];
                sb  = (rst || a == 0) ? 1'b0 : mbusy[a];
                fwd = !rst && wr_en && wr_addr != 0 && a == wr_addr;
                ed  = fwd ? wr_data : sd;
                eb  = fwd ? (issue_en && issue_addr == wr_addr) : sb;
                check($sformatf("byp_data%0d", i), rd_data_b[i*XLEN +: XLEN], ed);
                check($sformatf("byp_busy%0d", i), rd_busy_b[i], eb);
                check($sformatf("nb_data%0d", i), rd_data_n[i*XLEN +: XLEN], sd);
                check($sformatf("nb_busy%0d", i), rd_busy_n[i], sb);
            end
            check("byp_vec", busy_vec_b, rst ? '0 : mbusy);
            check("byp_count", busy_count_b, rst ? 0 : $countones(mbusy));
            check("nb_vec", busy_vec_n, rst ? '0 : mbusy);
            check("nb_count", busy_count_n, rst ? 0 : $countones(mbusy));
        end
    end

    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0; issue_addr = '0;
        cmp_on = 1'b1;
        sample();
        check("reset_count", busy_count_b, 0);
        check("reset_vec", busy_vec_b, 0);

        // x1 = 190 with x4 issued, then async reset mid-cycle.
        next(); rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'd190; issue_en = 1'b1; issue_addr = 5'd4;
        next(); rd_addr = {5'd0, 5'd1};
        sample();
        check("x1_read", rd_data_b[31:0], 32'd190);
        check("x4_count", busy_count_b, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_data0", rd_data_b[31:0], 0);
        check("midrst_count", busy_count_b, 0);
        check("midrst_nb_data0", rd_data_n[31:0], 0);
        next(); rst = 1'b0;

        // x0 ignores writes; multiple ports on one address.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD;
        next(); wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd450;
        next(); rd_addr = {5'd2, 5'd0};
        sample();
        check("x0_read", rd_data_b[31:0], 0);
        check("x0_busy", rd_busy_b[0], 0);
        check("x2_port1", rd_data_b[63:32], 32'd450);
        next(); rd_addr = {5'd2, 5'd2};
        sample();
        check("x2_both0", rd_data_b[31:0], 32'd450);
        check("x2_both1", rd_data_b[63:32], 32'd450);

        // Same-cycle forwarding vs stored-only read.
        next(); rd_addr = {5'd3, 5'd0}; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd77;
        sample();
        check("bypass_on", rd_data_b[63:32], 32'd77);
        check("bypass_off", rd_data_n[63:32], 0);
        next();
        sample();
        check("bypass_off_after", rd_data_n[63:32], 32'd77);

        // Scoreboard set and clear.
        next(); issue_en = 1'b1; issue_addr = 5'd5;
        next(); rd_addr = {5'd0, 5'd5};
        sample();
        check("x5_rd_busy", rd_busy_b[0], 1);
        check("x5_vec", busy_vec_b[5], 1);
        check("x5_count", busy_count_b, 1);
        next(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd7;
        next();
        sample();
        check("x5_clr_count", busy_count_b, 0);
        check("x5_data7", rd_data_b[31:0], 32'd7);

        // Issue and write on the same register.
        next(); issue_en = 1'b1; issue_addr = 5'd5;
        next(); issue_en = 1'b1; issue_addr = 5'd5; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd9;
        next();
        sample();
        check("iw_data", rd_data_b[31:0], 32'd9);
        check("iw_vec5", busy_vec_b[5], 1);
        check("iw_count", busy_count_b, 1);

        // Flush with a simultaneous issue.
        next(); issue_en = 1'b1; issue_addr = 5'd6; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'd66;
        next();
        sample();
        check("pre_flush_count", busy_count_b, 2);
        next(); flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd3;
        next(); rd_addr = {5'd6, 5'd5};
        sample();
        check("flush_vec", busy_vec_b, 32'h0000_0008);
        check("flush_count", busy_count_b, 1);
        check("flush_x5", rd_data_b[31:0], 32'd9);
        check("flush_x6", rd_data_b[63:32], 32'd66);

        // Randomised traffic over a narrow address range to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            next();
            rst        = 1'b0;
            rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 5'($urandom_range(0, 7));
            wr_data    = $urandom;
            issue_en   = ($urandom_range(0, 2) == 0);
            issue_addr = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
            end
        end
        next(); rst = 1'b0;
        sample();
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised multi-read-port integer register file with a per-register busy scoreboard for the pipelined core. It holds architectural register state and tracks which registers have an in-flight producer, so decode can detect RAW hazards. It sits between decode/issue (reads, issue marking) and writeback (writes, busy clearing).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of two, at least 2; AW = $clog2(NREGS)
- NREAD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return stored value only

Ports:
- clk  in  1  clock, rising edge active
- reset  in  1  asynchronous, active-high; clears all state
- rd_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NREAD*XLEN  read data, packed like rd_addr
- rd_busy  out  NREAD  busy bit of each read register
- wr_en  in  1  writeback enable
- wr_addr  in  AW  writeback register
- wr_data  in  XLEN  writeback data
- issue_en  in  1  mark issue_addr busy (new in-flight producer)
- issue_addr  in  AW  destination register of the issuing instruction
- flush  in  1  clear all busy bits (pipeline flush); data is kept
- busy_vec  out  NREGS  registered busy bits; bit 0 is always 0
- busy_count  out  AW+1  registered popcount of busy_vec

## Operation
- Register 0 is hardwired to zero.
  - Reads of addr 0 return 0 with rd_busy 0.
  - Writes and issues to addr 0 are ignored.
- Reads are combinational per port and independent.
  - Any number of ports may read the same address.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - A write to a non-busy register is legal: data is written and busy stays 0.
- Issue: on a rising edge with issue_en=1 and issue_addr!=0, busy[issue_addr] <= 1.
- Flush: on a rising edge with flush=1, every busy bit <= 0.
- Priority per register per edge, highest first: issue set, then flush clear / write clear, then hold.
  - Issue and write to the same address: data is written and busy stays 1 (new producer owns it).
  - Flush and issue together: only issue_addr is busy afterwards.
  - Flush and write together: data is written.
- BYPASS=1, when wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr in the current cycle:
  - rd_data[i] = wr_data;
  - rd_busy[i] = 0, unless issue_en=1 with issue_addr==wr_addr, in which case rd_busy[i] = 1.
- BYPASS=0: rd_data and rd_busy reflect stored state only.
- busy_count always equals the popcount of busy_vec. Maximum value is NREGS-1; no overflow is possible.
- Reset, asserted asynchronously at any time including mid-write or mid-issue:
  - all regs = 0, busy_vec = 0, busy_count = 0 immediately;
  - rd_data reads 0 for every address while reset is high;
  - inputs are ignored while reset is high.

## Timing
- Read latency: 0 cycles, combinational from rd_addr and stored state.
- Write visibility: next cycle for BYPASS=0; same cycle through rd_data for BYPASS=1.
- Issue and flush take effect on rd_busy, busy_vec and busy_count one cycle after the sampling edge.
- Reset values of outputs:
  - rd_data = 0 and rd_busy = 0 (all stored state is 0);
  - busy_vec = 0, busy_count = 0.
- Reset deassertion is synchronised externally; the first edge after deassertion is a normal edge.

## Test plan
- Reset/write/read: write x1=190, then read port0 addr 1 -> 190. Assert reset mid-cycle -> rd_data0 = 0 and busy_count = 0 before the next edge.
- x0 and multiport: write x0=0xDEAD and x2=450. Port0=0 -> 0; port1=2 -> 450; both ports at addr 2 -> 450 on each.
- Bypass: same cycle wr_en=1, wr_addr=3, wr_data=77, port1=3 with x3=0 stored.
  - BYPASS=1 -> rd_data1 = 77 before the edge.
  - BYPASS=0 -> rd_data1 = 0, then 77 after the edge.
- Scoreboard: issue x5.
  - Next cycle: rd_busy for x5 = 1, busy_vec[5] = 1, busy_count = 1.
  - Write x5=7 -> next cycle busy_count = 0 and x5 reads 7.
- Simultaneous issue and write: x5 busy, then issue_en and wr_en both on x5 with data 9 -> x5 = 9, busy_vec[5] stays 1, busy_count unchanged at 1.
- Flush: x5 and x6 busy; flush=1 with issue x3 -> next cycle busy_vec has only bit 3 set, busy_count = 1, and x5/x6 data are unchanged.
